ioctl_slot_loader: RTL and testbench

//  Multi-slot HPS download engine. Replaces the single rom_loaded flag and direct ioctl-to-RAM hookup.

---
 rtl/ioctl_loader_pkg.sv | 15 +
 rtl/ioctl_slot_loader_fifo.sv | 49 ++++
 rtl/ioctl_slot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_ioctl_slot_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types and slot numbering for the HPS ioctl download engine.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] SLOT_ROM  = 8'd0;
  localparam logic [7:0] SLOT_PAC  = 8'd1;
  localparam logic [7:0] SLOT_TAPE = 8'd2;

endpackage

// File: rtl/ioctl_slot_loader_fifo.sv
// Small synchronous FIFO; caller guarantees no push when full without a pop and no pop when empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Word storage; contents are don't-care until written
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == '0);
  assign count    = count_r;

endmodule

// File: rtl/ioctl_slot_loader.sv
// Multi-slot HPS download engine: buffers ioctl words, writes them bytewise to a relocated
// RAM window per slot, tracks per-slot loaded flags and holds the core in reset around a download.
module ioctl_slot_loader
  import ioctl_loader_pkg::*;
#(
  parameter int NUM_SLOTS   = 3,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter logic [NUM_SLOTS*ADDR_W-1:0]     SLOT_BASE = '0,
  parameter logic [NUM_SLOTS*(ADDR_W+1)-1:0] SLOT_SIZE = {NUM_SLOTS{{1'b1, {ADDR_W{1'b0}}}}}
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic [ADDR_W-1:0]    ioctl_addr,
  input  logic [15:0]          ioctl_dout,
  input  logic                 ioctl_wr,
  output logic                 ioctl_wait,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_din,
  output logic                 mem_wr,
  input  logic                 mem_busy,
  output logic [NUM_SLOTS-1:0] loaded,
  output logic                 core_reset,
  output logic [7:0]           active_slot,
  output logic                 overflow,
  output logic                 truncated
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HC_W   = $clog2(HOLD_CYCLES + 1);
  localparam int DATA_W = ADDR_W + 16;
  localparam logic [7:0] NUM_SLOTS_B = 8'(NUM_SLOTS);

  state_t state_r, state_nxt_s;
  logic dl_q_r, rise_s, fall_s, start_s, finish_s, drain_done_s;
  logic [HC_W-1:0] hold_cnt_r;
  logic core_reset_r, ioctl_wait_r, mem_wr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0] mem_din_r;
  logic [NUM_SLOTS-1:0] loaded_r;
  logic [7:0] active_slot_r;
  logic overflow_r, truncated_r, wrote_any_r;
  logic hi_pend_r;
  logic [7:0] hi_data_r;
  logic [ADDR_W-1:0] hi_addr_r;
  logic push_req_s, push_ok_s, drop_s, pop_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s, cnt_nxt_s;
  logic [DATA_W-1:0] head_s;
  logic slot_ok_s, in_range_s, emit_s, wr_now_s, trunc_s, cur_phase_s;
  logic [ADDR_W-1:0] base_s, cur_addr_s, nxt_addr_s;
  logic [ADDR_W:0] size_s, off_s;
  logic [7:0] cur_data_s;

  assign rise_s   = ioctl_download & ~dl_q_r;
  assign fall_s   = ~ioctl_download & dl_q_r;
  assign start_s  = (state_nxt_s == LOAD) && (state_r != LOAD);
  assign finish_s = (state_r == HOLD) && (state_nxt_s == IDLE);

  // Emitter is idle once nothing is queued, no high byte is pending and no write is stalled
  assign drain_done_s = fifo_empty_s && !hi_pend_r && !(mem_wr_r && mem_busy);

  assign push_req_s = ioctl_wr && ((state_r == LOAD) || (state_r == DRAIN));
  assign pop_s      = !mem_busy && !hi_pend_r && !fifo_empty_s;
  assign push_ok_s  = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s     = push_req_s && fifo_full_s && !pop_s;
  assign cnt_nxt_s  = fifo_count_s + CNT_W'(push_ok_s) - CNT_W'(pop_s);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push_ok_s),
    .push_data ({ioctl_addr, ioctl_dout}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Download sequencing: edges of ioctl_download drive the state, the hold counter ends it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (rise_s) state_nxt_s = LOAD;  else state_nxt_s = IDLE;
      LOAD:    if (fall_s) state_nxt_s = DRAIN; else state_nxt_s = LOAD;
      DRAIN:   if (drain_done_s) state_nxt_s = HOLD; else state_nxt_s = DRAIN;
      HOLD: begin
        if (rise_s)                 state_nxt_s = LOAD;
        else if (hold_cnt_r == '0)  state_nxt_s = IDLE;
        else                        state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Byte selection and relocation: phase 0 comes straight from the FIFO head at pop time
  always_comb begin
    slot_ok_s = (active_slot_r < NUM_SLOTS_B);
    base_s    = '0;
    size_s    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      base_s = (active_slot_r == 8'(i)) ? SLOT_BASE[i*ADDR_W +: ADDR_W] : base_s;
      size_s = (active_slot_r == 8'(i)) ? SLOT_SIZE[i*(ADDR_W+1) +: ADDR_W+1] : size_s;
    end
    if (hi_pend_r) begin
      cur_addr_s  = hi_addr_r;
      cur_data_s  = hi_data_r;
      cur_phase_s = 1'b1;
    end else begin
      cur_addr_s  = head_s[DATA_W-1:16];
      cur_data_s  = head_s[7:0];
      cur_phase_s = 1'b0;
    end
    off_s      = {1'b0, cur_addr_s} + {{ADDR_W{1'b0}}, cur_phase_s};
    in_range_s = (off_s < size_s);
    emit_s     = !mem_busy && (hi_pend_r || !fifo_empty_s);
    wr_now_s   = emit_s && slot_ok_s && in_range_s;
    trunc_s    = emit_s && slot_ok_s && !in_range_s;
    nxt_addr_s = base_s + off_s[ADDR_W-1:0];
  end

  // State register, core reset request, back-pressure and hold timer
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      dl_q_r       <= 1'b0;
      core_reset_r <= 1'b0;
      ioctl_wait_r <= 1'b0;
      hold_cnt_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      dl_q_r       <= ioctl_download;
      core_reset_r <= (state_nxt_s != IDLE);
      ioctl_wait_r <= (cnt_nxt_s >= CNT_W'(FIFO_DEPTH - 1));
      if ((state_r == DRAIN) && (state_nxt_s == HOLD))
        hold_cnt_r <= HC_W'(HOLD_CYCLES - 1);
      else if ((state_r == HOLD) && (hold_cnt_r != '0))
        hold_cnt_r <= hold_cnt_r - HC_W'(1);
    end
  end

  // Per-download status; loaded is only granted for a clean, non-empty download
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      active_slot_r <= 8'd0;
      overflow_r    <= 1'b0;
      truncated_r   <= 1'b0;
      wrote_any_r   <= 1'b0;
      loaded_r      <= '0;
    end else if (start_s) begin
      active_slot_r <= ioctl_index;
      overflow_r    <= 1'b0;
      truncated_r   <= 1'b0;
      wrote_any_r   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (ioctl_index == 8'(i)) loaded_r[i] <= 1'b0;
    end else begin
      if (drop_s)   overflow_r  <= 1'b1;
      if (trunc_s)  truncated_r <= 1'b1;
      if (wr_now_s) wrote_any_r <= 1'b1;
      if (finish_s && slot_ok_s && !overflow_r && wrote_any_r)
        for (int i = 0; i < NUM_SLOTS; i++)
          if (active_slot_r == 8'(i)) loaded_r[i] <= 1'b1;
    end
  end

  // RAM port and pending high byte; everything freezes while the RAM is busy
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_wr_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= 8'd0;
      hi_pend_r  <= 1'b0;
      hi_data_r  <= 8'd0;
      hi_addr_r  <= '0;
    end else if (!mem_busy) begin
      mem_wr_r <= wr_now_s;
      if (wr_now_s) begin
        mem_addr_r <= nxt_addr_s;
        mem_din_r  <= cur_data_s;
      end
      if (hi_pend_r) begin
        hi_pend_r <= 1'b0;
      end else if (pop_s) begin
        hi_pend_r <= 1'b1;
        hi_data_r <= head_s[15:8];
        hi_addr_r <= head_s[DATA_W-1:16];
      end
    end
  end

  assign ioctl_wait  = ioctl_wait_r;
  assign mem_addr    = mem_addr_r;
  assign mem_din     = mem_din_r;
  assign mem_wr      = mem_wr_r;
  assign loaded      = loaded_r;
  assign core_reset  = core_reset_r;
  assign active_slot = active_slot_r;
  assign overflow    = overflow_r;
  assign truncated   = truncated_r;

endmodule

// File: tb/tb_ioctl_slot_loader.sv
// Directed bench for ioctl_slot_loader: slot relocation, truncation, overflow, reset abort, bad slot.
module tb_ioctl_slot_loader;
  import ioctl_loader_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [15:0] ioctl_addr = 16'd0;
  logic [15:0] ioctl_dout = 16'd0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic        mem_busy = 1'b0;
  logic [2:0]  loaded;
  logic        core_reset;
  logic [7:0]  active_slot;
  logic        overflow;
  logic        truncated;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] log_a[$];
  logic [7:0]  log_d[$];

  always #5 clk_sys = ~clk_sys;

  ioctl_slot_loader #(
    .NUM_SLOTS(3), .ADDR_W(16), .FIFO_DEPTH(4), .HOLD_CYCLES(16),
    .SLOT_BASE({16'h0000, 16'hC000, 16'h0000}),
    .SLOT_SIZE({17'd3, 17'h10000, 17'h10000})
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_wr(mem_wr), .mem_busy(mem_busy), .loaded(loaded),
    .core_reset(core_reset), .active_slot(active_slot), .overflow(overflow),
    .truncated(truncated)
  );

  // Record every byte the RAM actually accepts
  always @(posedge clk_sys) begin
    if (mem_wr === 1'b1 && mem_busy === 1'b0) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    logic [31:0] obs;
    obs = (idx < log_a.size()) ? {8'd0, log_a[idx], log_d[idx]} : 32'hFFFF_FFFF;
    check(tag, obs, {8'd0, a, d});
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic send_word(input logic [15:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (core_reset !== 1'b0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, {31'd0, core_reset}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_outputs", {mem_wr, core_reset, ioctl_wait, overflow, truncated, loaded}, 32'd0);
    check("rst_slot_addr", {active_slot, mem_addr, mem_din}, 32'd0);

    // 1: slot 0, two words, exact pop-to-write latency
    log_a.delete(); log_d.delete();
    start_dl(SLOT_ROM);
    check("t1_core_reset_on", {31'd0, core_reset}, 32'd1);
    send_word(16'h0000, 16'h2211);
    check("t1_no_wr_yet", {31'd0, mem_wr}, 32'd0);
    send_word(16'h0002, 16'h4433);
    check("t1_first_wr", {15'd0, mem_wr, mem_addr, mem_din} >> 0, {15'd0, 1'b1, 16'h0000, 8'h11});
    end_dl();
    check("t1_loaded_busy", {29'd0, loaded}, 32'd0);
    wait_idle("t1_idle", n);
    check("t1_nbytes", log_a.size(), 32'd4);
    check_log("t1_b0", 0, 16'h0000, 8'h11);
    check_log("t1_b1", 1, 16'h0001, 8'h22);
    check_log("t1_b2", 2, 16'h0002, 8'h33);
    check_log("t1_b3", 3, 16'h0003, 8'h44);
    check("t1_loaded", {29'd0, loaded}, 32'd1);

    // 2: slot 1 relocated to 0xC000; hold lasts 16 cycles after the last byte
    log_a.delete(); log_d.delete();
    start_dl(SLOT_PAC);
    send_word(16'h0010, 16'hBBAA);
    end_dl();
    wait_idle("t2_idle", n);
    check("t2_hold_len", n, 32'd18);
    check("t2_nbytes", log_a.size(), 32'd2);
    check_log("t2_b0", 0, 16'hC010, 8'hAA);
    check_log("t2_b1", 1, 16'hC011, 8'hBB);
    check("t2_loaded", {29'd0, loaded}, 32'b011);
    check("t2_slot", {24'd0, active_slot}, 32'd1);

    // 3: slot 2 sized 3 bytes, high byte falls past the end
    log_a.delete(); log_d.delete();
    start_dl(SLOT_TAPE);
    send_word(16'h0002, 16'h6655);
    end_dl();
    wait_idle("t3_idle", n);
    check("t3_nbytes", log_a.size(), 32'd1);
    check_log("t3_b0", 0, 16'h0002, 8'h55);
    check("t3_trunc", {31'd0, truncated}, 32'd1);
    check("t3_loaded", {29'd0, loaded}, 32'b111);

    // 4: RAM busy, five back-to-back words into a 4-deep FIFO
    log_a.delete(); log_d.delete();
    start_dl(SLOT_ROM);
    check("t4_loaded_clr", {29'd0, loaded}, 32'b110);
    check("t4_trunc_clr", {31'd0, truncated}, 32'd0);
    mem_busy = 1'b1;
    send_word(16'h0000, 16'h1111);
    send_word(16'h0002, 16'h2222);
    check("t4_wait_cnt2", {31'd0, ioctl_wait}, 32'd0);
    send_word(16'h0004, 16'h3333);
    check("t4_wait_cnt3", {31'd0, ioctl_wait}, 32'd1);
    check("t4_ovf_before", {31'd0, overflow}, 32'd0);
    send_word(16'h0006, 16'h4444);
    send_word(16'h0008, 16'h5555);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_no_wr", {31'd0, mem_wr}, 32'd0);
    end_dl();
    mem_busy = 1'b0;
    wait_idle("t4_idle", n);
    check("t4_nbytes", log_a.size(), 32'd8);
    check_log("t4_b7", 7, 16'h0007, 8'h44);
    check("t4_loaded", {29'd0, loaded}, 32'b110);

    // 5: reset in the middle of a load, then a clean download
    start_dl(SLOT_PAC);
    send_word(16'h0020, 16'h1234);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("t5_rst_outputs", {mem_wr, core_reset, ioctl_wait, overflow, truncated, loaded}, 32'd0);
    check("t5_rst_slot", {24'd0, active_slot}, 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    log_a.delete(); log_d.delete();
    start_dl(SLOT_ROM);
    send_word(16'h0004, 16'hA55A);
    end_dl();
    wait_idle("t5_idle", n);
    check("t5_nbytes", log_a.size(), 32'd2);
    check_log("t5_b0", 0, 16'h0004, 8'h5A);
    check_log("t5_b1", 1, 16'h0005, 8'hA5);
    check("t5_loaded", {29'd0, loaded}, 32'b001);

    // 6: out-of-range slot is drained without writes or flag changes
    log_a.delete(); log_d.delete();
    start_dl(8'd7);
    check("t6_core_reset_on", {31'd0, core_reset}, 32'd1);
    check("t6_slot", {24'd0, active_slot}, 32'd7);
    send_word(16'h0000, 16'hFFEE);
    end_dl();
    wait_idle("t6_idle", n);
    check("t6_nbytes", log_a.size(), 32'd0);
    check("t6_loaded", {29'd0, loaded}, 32'b001);
    check("t6_flags", {30'd0, overflow, truncated}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
